// File: rtl/arb4_rr_pkg.sv
// arb4_rr_pkg: shared definitions for the four-channel round-robin arbiter.
//   SEL_A..SEL_D : 2-bit select codes (0=A .. 3=D), also used by Mux2 consumers
//   PTR_RST      : last-grant pointer value after reset (A gets first priority)
//   state_e      : output-stage state, IDLE (no word held) / HOLD (word held)
package arb4_rr_pkg;

   localparam logic [1:0] SEL_A   = 2'd0;
   localparam logic [1:0] SEL_B   = 2'd1;
   localparam logic [1:0] SEL_C   = 2'd2;
   localparam logic [1:0] SEL_D   = 2'd3;

   localparam logic [1:0] PTR_RST = SEL_D;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/arb4_rr_mux2.sv
// Mux2: two-level 4:1 word select.
//   a_in..d_in : WIDTH-bit candidate words
//   s_in       : select code (SEL_A..SEL_D)
//   y_out      : selected word
// The first level picks within {A,B} and {C,D} on s_in[0]; the second level
// picks between the pairs on s_in[1].
module Mux2
   import arb4_rr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] c_in,
   input  logic [WIDTH-1:0] d_in,
   input  logic [1:0]       s_in,
   output logic [WIDTH-1:0] y_out
);

   logic [WIDTH-1:0] lo_y;
   logic [WIDTH-1:0] hi_y;

   always_comb begin
      lo_y  = (s_in[0] == SEL_B[0]) ? b_in : a_in;
      hi_y  = (s_in[0] == SEL_D[0]) ? d_in : c_in;
      y_out = (s_in[1] == SEL_C[1]) ? hi_y : lo_y;
   end

endmodule

// File: rtl/arb4_rr.sv
// arb4_rr: four-channel round-robin arbiter with a registered single-entry
// output stage.
//   clk_in, rst_in       : clock, asynchronous active-high reset
//   req_in[3:0]          : per-channel request (bit 0 = A .. bit 3 = D)
//   a_in..d_in           : channel data words
//   ack_out[3:0]         : one-hot accept pulse, high in the capture cycle
//   valid_out / ready_in : output handshake; a word transfers on a rising edge
//                          where both are 1. valid_out only depends on state,
//                          and a new word may be captured in the same cycle the
//                          held one transfers out (full rate, no bubble).
//   data_out, s_out      : registered captured word and its select code
module arb4_rr
   import arb4_rr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [3:0]       req_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] c_in,
   input  logic [WIDTH-1:0] d_in,
   output logic [3:0]       ack_out,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [WIDTH-1:0] data_out,
   output logic [1:0]       s_out
);

   state_e           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       s_q, s_d;

   logic [1:0]       grant;
   logic             cap;
   logic [WIDTH-1:0] mux_y;

   // Rotate requests so the channel after ptr sits at bit 0, take the lowest
   // set bit, then rotate the index back into channel numbering.
   function automatic logic [1:0] rr_grant(input logic [3:0] req,
                                           input logic [1:0] ptr);
      logic [3:0] rot;
      logic [1:0] k;
      for (int i = 0; i < 4; i++) begin
         rot[i] = req[ptr + 2'(i) + 2'd1];
      end
      k = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (rot[i]) begin
            k = 2'(i);
         end
      end
      return ptr + k + 2'd1;
   endfunction

   Mux2 #(.WIDTH(WIDTH)) u_mux (
      .a_in  (a_in),
      .b_in  (b_in),
      .c_in  (c_in),
      .d_in  (d_in),
      .s_in  (grant),
      .y_out (mux_y)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      s_d     = s_q;
      ack_out = 4'b0000;

      grant = rr_grant(req_in, ptr_q);
      // Held low during reset so no upstream word is acked and then dropped.
      cap   = (|req_in) && ((state_q == ST_IDLE) || ready_in) && !rst_in;

      if (cap) begin
         state_d = ST_HOLD;
         ptr_d   = grant;
         data_d  = mux_y;
         s_d     = grant;
         ack_out = 4'b0001 << grant;
      end else if ((state_q == ST_HOLD) && ready_in) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         ptr_q   <= PTR_RST;
         data_q  <= '0;
         s_q     <= SEL_A;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         s_q     <= s_d;
      end
   end

   assign valid_out = (state_q == ST_HOLD);
   assign data_out  = data_q;
   assign s_out     = s_q;

endmodule

// File: doc/arb4_rr.md
# arb4_rr

Four-channel round-robin arbiter with a registered single-entry output stage, sitting directly upstream of the two-level 4:1 select path. It chooses one of four requesting sources and drives the matching 2-bit select code. It captures the selected word through an instance of the existing 4:1 `Mux2` and presents the result on a valid/ready output handshake. Downstream logic consumes `s_out` and `data_out` together, with no further muxing.

## Interface

Reset is asynchronous and active-high; one clock.

- `WIDTH`, default 8, data word width of every channel and of `data_out`.

- `clk_in`  input  1  clock; all state changes on the rising edge.
- `rst_in`  input  1  asynchronous, active-high reset.
- `req_in`  input  4  per-channel request; bit 0 is channel A, bit 3 is channel D.
- `a_in`, `b_in`, `c_in`, `d_in`  input  WIDTH each  channel data; must be held stable while the matching request bit is high and not yet acked.
- `ack_out`  output  4  one-hot accept pulse; bit g is high in the cycle channel g's word is captured.
- `valid_out`  output  1  `data_out` and `s_out` hold an undelivered word.
- `ready_in`  input  1  downstream accepts the word this cycle when `valid_out` is 1.
- `data_out`  output  WIDTH  registered captured word.
- `s_out`  output  2  registered select code of the captured word (0=A, 1=B, 2=C, 3=D).

## Operation

- State: `valid_out` flag (IDLE when 0, HOLD when 1), last-grant pointer `ptr[1:0]`, output registers.
- `cap` = `|req_in & (~valid_out | ready_in)`, the capture enable.
- Grant `g` is the first requesting channel in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
- On `cap`:
  - `data_out` <= `Mux2(a,b,c,d, g)`;
  - `s_out` <= g;
  - `ptr` <= g;
  - `valid_out` <= 1;
  - `ack_out` = onehot(g), combinational in the same cycle.
- HOLD with `ready_in` = 1 and no request: `valid_out` <= 0; `data_out` and `s_out` retain their values.
- HOLD with `ready_in` = 0:
  - all registers hold;
  - `ack_out` = 0 regardless of `req_in`.
- `ack_out` is 0 whenever `cap` is 0. It depends combinationally on `req_in`, `ready_in` and the state.
- A requester may withdraw `req_in` before ack. The withdrawn word is never captured.
- Reset values:
  - `valid_out` = 0;
  - `data_out` = 0;
  - `s_out` = 0;
  - `ack_out` = 0;
  - `ptr` = 3, so channel A has first priority after reset.
- Reset mid-HOLD discards the held word. The upstream producer was already acked, so the word is lost; this is the intended behaviour.

## Timing

- Request to `valid_out`: 1 cycle (captured on the edge ending the ack cycle).
- Throughput: one word per cycle while `ready_in` = 1 and any request is high (back-to-back capture in HOLD).
- Handshake transfer occurs on an edge where `valid_out` and `ready_in` are both 1.
- Simultaneous transfer-out and capture-in in one cycle is the normal full-rate case. No bubble is inserted.
- Fairness: a continuously requesting channel is granted at least once every 4 captures.
- No combinational path from `req_in` or data to `valid_out`, `data_out` or `s_out`.

## Structure

- Shared package/include holds:
  - select encoding constants `SEL_A`..`SEL_D` (2'd0..2'd3), also used by the `Mux2` consumers;
  - the reset pointer value.
- Sub-module: one `Mux2 #(WIDTH)` instance for the data path, with select driven by combinational `g`.
- Grant logic is a local rotate, priority-encode, rotate-back function. No separate module.

## Test plan

- Reset then a single request:
  - stimulus: `req_in` = 4'b0100, `c_in` = 8'h5A, `ready_in` = 1;
  - response: `ack_out` = 4'b0100 in the same cycle; next cycle `valid_out` = 1, `data_out` = 8'h5A, `s_out` = 2.
- All four requesting with `ready_in` = 1 for 8 cycles:
  - grants are A,B,C,D,A,B,C,D;
  - `valid_out` stays 1 continuously;
  - `s_out` sequence is 0,1,2,3,0,1,2,3.
- Backpressure:
  - stimulus: capture B (`b_in` = 8'h11), then `ready_in` = 0 for 3 cycles with all requests high;
  - response: `data_out` = 8'h11 and `s_out` = 1 stable; `ack_out` = 0 for all 3 cycles;
  - when `ready_in` rises, C is acked in that same cycle.
- Drain:
  - stimulus: HOLD with `ready_in` = 1 and `req_in` = 0;
  - response: `valid_out` falls next cycle; `data_out` is unchanged.
- Reset asserted asynchronously mid-HOLD, with `ptr` = 2:
  - `valid_out`, `data_out` and `s_out` clear immediately;
  - after release, with all requests high, the first grant is A.
- Withdrawal:
  - stimulus: D requests while `ready_in` = 0 in HOLD, then drops `req_in` before `ready_in` rises;
  - response: D is never acked and no capture occurs.
